// File: rtl/sram_arb.sv
// sram_arb: two-requester arbiter for one word port of the capability SRAM.
// Round-robin grant, a lock that keeps a requester as owner across
// back-to-back accesses (with an idle timeout), and one-cycle read-response
// routing back to the requester that issued the read.
module sram_arb #(
   parameter int unsigned SramAw      = 15,
   parameter int unsigned DataWidth   = 32,
   parameter int unsigned LockTimeout = 4
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic [1:0]                req_i,
   input  logic [1:0]                we_i,
   input  logic [1:0]                lock_i,
   input  logic [1:0][SramAw-1:0]    addr_i,
   input  logic [1:0][DataWidth-1:0] wdata_i,
   input  logic [1:0][DataWidth-1:0] wmask_i,
   input  logic [1:0]                wcap_i,
   output logic [1:0]                gnt_o,
   output logic [1:0]                rvalid_o,
   output logic [DataWidth-1:0]      rdata_o,
   output logic                      rcap_o,
   output logic                      mem_req_o,
   output logic                      mem_we_o,
   output logic [SramAw-1:0]         mem_addr_o,
   output logic [DataWidth-1:0]      mem_wdata_o,
   output logic [DataWidth-1:0]      mem_wmask_o,
   output logic                      mem_wcap_o,
   input  logic [DataWidth-1:0]      mem_rdata_i,
   input  logic                      mem_rcap_i,
   output logic                      locked_o
);

   localparam int unsigned CntW = $clog2(LockTimeout + 1);

   typedef enum logic {
      Unlocked,
      Locked
   } state_e;

   state_e            state_q, state_d;
   logic              owner_q, owner_d;
   logic              prio_q, prio_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [1:0]        rv_q;
   logic              sel;

   // Index of the granted requester; only meaningful while a grant is active.
   assign sel = gnt_o[1];

   // State, priority pointer, idle counter and pending read routing.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= Unlocked;
         owner_q <= 1'b0;
         prio_q  <= 1'b0;
         cnt_q   <= '0;
         rv_q    <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         prio_q  <= prio_d;
         cnt_q   <= cnt_d;
         rv_q    <= gnt_o & ~we_i;
      end
   end

   // Grant: only the owner while locked, otherwise round-robin on contention.
   always_comb begin
      gnt_o = '0;
      if (state_q == Locked) begin
         gnt_o[owner_q] = req_i[owner_q];
      end else if (&req_i) begin
         gnt_o[prio_q] = 1'b1;
      end else begin
         gnt_o = req_i;
      end
   end

   // Next state: lock/unlock on grant, idle timeout releases a silent owner.
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      prio_d  = prio_q;
      cnt_d   = cnt_q;
      if (|gnt_o) begin
         prio_d = ~sel;
         cnt_d  = '0;
         if (lock_i[sel]) begin
            state_d = Locked;
            owner_d = sel;
         end else begin
            state_d = Unlocked;
         end
      end else if (state_q == Locked) begin
         // Release happens on the cycle the count would reach LockTimeout, so
         // the counter never has to hold a value beyond it.
         if (32'(cnt_q) + 32'd1 >= LockTimeout) begin
            state_d = Unlocked;
            prio_d  = ~owner_q;
            cnt_d   = '0;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // SRAM port mux from the granted requester; write controls forced low when idle.
   always_comb begin
      mem_req_o   = |gnt_o;
      mem_we_o    = mem_req_o & we_i[sel];
      mem_addr_o  = addr_i[sel];
      mem_wdata_o = wdata_i[sel];
      mem_wmask_o = mem_req_o ? wmask_i[sel] : '0;
      mem_wcap_o  = mem_req_o & wcap_i[sel];
   end

   assign rvalid_o = rv_q;
   assign rdata_o  = mem_rdata_i;
   assign rcap_o   = mem_rcap_i;
   assign locked_o = (state_q == Locked);

endmodule

// File: tb/tb_sram_arb.sv
// Bench for sram_arb: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural model.
module tb_sram_arb;

   localparam int unsigned AW = 15;
   localparam int unsigned DW = 32;
   localparam int unsigned LT = 4;

   logic                clk = 1'b0;
   logic                rst_n;
   logic [1:0]          req_i, we_i, lock_i, wcap_i;
   logic [1:0][AW-1:0]  addr_i;
   logic [1:0][DW-1:0]  wdata_i, wmask_i;
   logic [1:0]          gnt_o, rvalid_o;
   logic [DW-1:0]       rdata_o;
   logic                rcap_o;
   logic                mem_req_o, mem_we_o, mem_wcap_o;
   logic [AW-1:0]       mem_addr_o;
   logic [DW-1:0]       mem_wdata_o, mem_wmask_o;
   logic [DW-1:0]       mem_rdata_i = '0;
   logic                mem_rcap_i = 1'b0;
   logic                locked_o;

   int vec = 0;
   int err = 0;

   always #5 clk = ~clk;

   sram_arb #(.SramAw(AW), .DataWidth(DW), .LockTimeout(LT)) dut (
      .clk_i(clk), .rst_ni(rst_n), .req_i(req_i), .we_i(we_i), .lock_i(lock_i),
      .addr_i(addr_i), .wdata_i(wdata_i), .wmask_i(wmask_i), .wcap_i(wcap_i),
      .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o), .rcap_o(rcap_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_wmask_o(mem_wmask_o), .mem_wcap_o(mem_wcap_o),
      .mem_rdata_i(mem_rdata_i), .mem_rcap_i(mem_rcap_i), .locked_o(locked_o)
   );

   task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
      vec++;
      if (a !== e) begin
         err++;
         $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
      end
   endtask

   // SRAM macro stand-in: registered read, masked write.
   logic [DW-1:0] sram_d [32];
   logic          sram_c [32];
   always @(posedge clk) begin
      if (mem_req_o) begin
         if (mem_we_o) begin
            sram_d[mem_addr_o[4:0]] <= (sram_d[mem_addr_o[4:0]] & ~mem_wmask_o) |
                                       (mem_wdata_o & mem_wmask_o);
            sram_c[mem_addr_o[4:0]] <= mem_wcap_o;
         end else begin
            mem_rdata_i <= sram_d[mem_addr_o[4:0]];
            mem_rcap_i  <= sram_c[mem_addr_o[4:0]];
         end
      end
   end

   // Behavioural model: ownership, favoured requester, idle cycles, expected read.
   logic [DW-1:0] exp_d [32];
   logic          exp_c [32];
   int            m_locked, m_owner, m_prio, m_idle, m_rv, m_last_w;
   logic [DW-1:0] m_rd;
   logic          m_rc;

   function automatic int winner();
      if (m_locked != 0) return req_i[m_owner] ? m_owner : -1;
      if (req_i == 2'b11) return m_prio;
      if (req_i[0]) return 0;
      if (req_i[1]) return 1;
      return -1;
   endfunction

   always @(posedge clk or negedge rst_n) begin : model
      int w;
      int a;
      if (!rst_n) begin
         m_locked <= 0; m_owner <= 0; m_prio <= 0; m_idle <= 0;
         m_rv <= -1; m_last_w <= -1;
      end else begin
         w = winner();
         m_last_w <= w;
         m_rv <= -1;
         if (w >= 0) begin
            a = int'(addr_i[w][4:0]);
            if (we_i[w]) begin
               exp_d[a] = (exp_d[a] & ~wmask_i[w]) | (wdata_i[w] & wmask_i[w]);
               exp_c[a] = wcap_i[w];
            end else begin
               m_rv <= w;
               m_rd <= exp_d[a];
               m_rc <= exp_c[a];
            end
            m_prio <= 1 - w;
            m_idle <= 0;
            if (lock_i[w]) begin
               m_locked <= 1; m_owner <= w;
            end else begin
               m_locked <= 0;
            end
         end else if (m_locked != 0) begin
            if (m_idle + 1 >= int'(LT)) begin
               m_locked <= 0; m_prio <= 1 - m_owner; m_idle <= 0;
            end else begin
               m_idle <= m_idle + 1;
            end
         end
      end
   end

   // Every-cycle comparison of DUT outputs against the model.
   always @(negedge clk) begin : compare
      int w;
      if (rst_n) begin
         w = winner();
         chk("gnt", 64'(gnt_o), (w < 0) ? 64'd0 : 64'(2'b01 << w));
         chk("mem_req", 64'(mem_req_o), 64'(w >= 0));
         chk("mem_we", 64'(mem_we_o), (w < 0) ? 64'd0 : 64'(we_i[w]));
         chk("mem_wmask", 64'(mem_wmask_o), (w < 0) ? 64'd0 : 64'(wmask_i[w]));
         chk("mem_wcap", 64'(mem_wcap_o), (w < 0) ? 64'd0 : 64'(wcap_i[w]));
         if (w >= 0) begin
            chk("mem_addr", 64'(mem_addr_o), 64'(addr_i[w]));
            chk("mem_wdata", 64'(mem_wdata_o), 64'(wdata_i[w]));
         end
         chk("rvalid", 64'(rvalid_o), (m_rv < 0) ? 64'd0 : 64'(2'b01 << m_rv));
         if (m_rv >= 0) begin
            chk("rdata", 64'(rdata_o), 64'(m_rd));
            chk("rcap", 64'(rcap_o), 64'(m_rc));
         end
         chk("locked", 64'(locked_o), 64'(m_locked != 0));
      end
   end

   task automatic set_req(input int i, input bit r, input bit w, input bit lk,
                          input int a, input logic [DW-1:0] d, input logic [DW-1:0] m,
                          input bit c);
      req_i[i] = r; we_i[i] = w; lock_i[i] = lk; addr_i[i] = AW'(a);
      wdata_i[i] = d; wmask_i[i] = m; wcap_i[i] = c;
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step(); step();
      rst_n = 1'b1;
   endtask

   task automatic preload(input int a, input logic [DW-1:0] d, input bit c);
      sram_d[a] = d; sram_c[a] = c; exp_d[a] = d; exp_c[a] = c;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) preload(i, '0, 1'b0);
      req_i = '0; we_i = '0; lock_i = '0; wcap_i = '0;
      addr_i = '0; wdata_i = '0; wmask_i = '0;
      rst_n = 1'b0;
      step(); step();
      @(negedge clk);
      chk("rst_gnt", 64'(gnt_o), 64'd0);
      chk("rst_rvalid", 64'(rvalid_o), 64'd0);
      chk("rst_locked", 64'(locked_o), 64'd0);
      chk("rst_mem_req", 64'(mem_req_o), 64'd0);
      #1 rst_n = 1'b1;
      step();

      // Single read of 0x10 by requester 0.
      preload(16, 32'hDEADBEEF, 1'b1);
      set_req(0, 1, 0, 0, 16, '0, '0, 0);
      @(negedge clk); chk("t1_gnt", 64'(gnt_o), 64'h1);
      step(); set_req(0, 0, 0, 0, 0, '0, '0, 0);
      @(negedge clk);
      chk("t1_rvalid", 64'(rvalid_o), 64'h1);
      chk("t1_rdata", 64'(rdata_o), 64'hDEADBEEF);
      chk("t1_rcap", 64'(rcap_o), 64'h1);
      step();

      // Continuous contention alternates starting from requester 0.
      do_reset();
      set_req(0, 1, 0, 0, 1, '0, '0, 0);
      set_req(1, 1, 0, 0, 2, '0, '0, 0);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk); chk("t2_gnt", 64'(gnt_o), (k % 2 == 0) ? 64'h1 : 64'h2);
         step();
      end
      req_i = '0;
      step();

      // Locked two-half capability write by requester 1 against requester 0.
      set_req(0, 1, 0, 0, 3, '0, '0, 0);
      step();
      set_req(1, 1, 1, 1, 4, 32'h1111_2222, '1, 1);
      @(negedge clk);
      chk("t3_gnt_a", 64'(gnt_o), 64'h2);
      chk("t3_wcap_a", 64'(mem_wcap_o), 64'h1);
      step(); set_req(1, 1, 1, 0, 5, 32'h3333_4444, '1, 1);
      @(negedge clk);
      chk("t3_gnt_b", 64'(gnt_o), 64'h2);
      chk("t3_wcap_b", 64'(mem_wcap_o), 64'h1);
      step(); req_i[1] = 1'b0;
      @(negedge clk); chk("t3_gnt_c", 64'(gnt_o), 64'h1);
      step(); req_i = '0;
      step();

      // Lock owner goes idle; requester 1 waits out the timeout.
      set_req(0, 1, 0, 1, 6, '0, '0, 0);
      @(negedge clk); chk("t4_gnt_lock", 64'(gnt_o), 64'h1);
      step(); req_i[0] = 1'b0; set_req(1, 1, 1, 0, 7, 32'h55AA55AA, '1, 0);
      for (int k = 0; k < int'(LT); k++) begin
         @(negedge clk);
         chk("t4_stall", 64'(gnt_o), 64'h0);
         chk("t4_locked", 64'(locked_o), 64'h1);
         step();
      end
      @(negedge clk);
      chk("t4_unlocked", 64'(locked_o), 64'h0);
      chk("t4_gnt_r1", 64'(gnt_o), 64'h2);
      step(); req_i = '0;
      step();

      // Read then write back to back: only the read returns rvalid.
      set_req(0, 1, 0, 0, 16, '0, '0, 0);
      step(); req_i[0] = 1'b0; set_req(1, 1, 1, 0, 8, 32'h0BADF00D, '1, 1);
      @(negedge clk);
      chk("t5_rvalid_rd", 64'(rvalid_o), 64'h1);
      chk("t5_gnt_wr", 64'(gnt_o), 64'h2);
      step(); req_i = '0;
      @(negedge clk); chk("t5_rvalid_wr", 64'(rvalid_o), 64'h0);
      step();

      // Reset while locked with a read outstanding.
      set_req(0, 1, 0, 1, 16, '0, '0, 0);
      step(); req_i = '0;
      #1 rst_n = 1'b0;
      #1;
      chk("t6_rvalid", 64'(rvalid_o), 64'h0);
      chk("t6_locked", 64'(locked_o), 64'h0);
      step(); step(); rst_n = 1'b1;
      set_req(0, 1, 0, 0, 1, '0, '0, 0);
      set_req(1, 1, 0, 0, 2, '0, '0, 0);
      @(negedge clk); chk("t6_gnt", 64'(gnt_o), 64'h1);
      step(); req_i = '0;
      step();

      // Randomized traffic; requests are held until the model shows a grant.
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if ($urandom_range(0, 499) == 0) begin
            req_i = '0;
            do_reset();
         end
         for (int i = 0; i < 2; i++) begin
            if (!req_i[i] || m_last_w == i) begin
               if ($urandom_range(0, 99) < ((m_last_w == i && lock_i[i]) ? 70 : 55))
                  set_req(i, 1, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                          int'($urandom_range(0, 7)), $urandom, $urandom, 1'($urandom_range(0, 1)));
               else
                  set_req(i, 0, 0, 0, 0, '0, '0, 0);
            end
         end
         step();
      end
      req_i = '0;
      step(); step();

      $display("== %0d vectors applied, %0d miscompares ==", vec, err);
      $finish;
   end

endmodule
